// File: rtl/ref_mem_pkg.sv
// Purpose: shared geometry, widths and FSM state type for the reference-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Geometry: one 32-pixel row per beat, 8 groups of 4 banks, 128 addresses per bank,
// so a full load is 1024 rows.
package ref_mem_pkg;

  localparam int PIXEL    = 8;
  localparam int X        = 32;
  localparam int BANKS    = 32;
  localparam int ADDR_W   = 7;
  localparam int GRP      = 4;
  localparam int NGRP     = BANKS / GRP;
  localparam int MAX_ROWS = NGRP * (2 ** ADDR_W);

  localparam int DATA_W   = PIXEL * X;
  localparam int ROW_W    = $clog2(MAX_ROWS);  // row index 0..MAX_ROWS-1
  localparam int CNT_W    = ROW_W + 1;         // row count 0..MAX_ROWS (and beyond, for errors)
  localparam int GSEL_W   = $clog2(NGRP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/ref_mem_loader_if.sv
// Purpose: search-window stream in, reference-memory write port out.
// Latency: n/a (signal bundle).
// Backpressure: s_ready from the loader; the memory write port has no backpressure.
// master = loader side (consumes stream, drives memory); slave = source/memory side.
interface ref_mem_loader_if;
  import ref_mem_pkg::*;

  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       ref_input;
  logic [BANKS-1:0]        Bank_sel;
  logic [BANKS*ADDR_W-1:0] write_address_all;

  modport master (
    input  s_data, s_valid,
    output s_ready, ref_input, Bank_sel, write_address_all
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, ref_input, Bank_sel, write_address_all
  );

endinterface

// File: rtl/ref_wr_addr_gen.sv
// Purpose: map a row index to per-bank write enables and per-bank write addresses.
// Latency: combinational.
// Backpressure: none.
// Ports: row (in) row index; bank_sel (out) one group of GRP banks; addr_all (out) packed
// per-bank addresses, unselected banks 0. Macro REF_LOADER_SKEW_EN adds the bank group
// index to each address (diagonal skew, wrapping modulo 2**ADDR_W).
module ref_wr_addr_gen
  import ref_mem_pkg::*;
(
  input  logic [ROW_W-1:0]        row,
  output logic [BANKS-1:0]        bank_sel,
  output logic [BANKS*ADDR_W-1:0] addr_all
);

  logic [GSEL_W-1:0] grp;
  logic [ADDR_W-1:0] base;

  // Low row bits pick the bank group, high bits give the in-bank line.
  assign grp  = row[GSEL_W-1:0];
  assign base = row[ROW_W-1:GSEL_W];

  always_comb begin
    bank_sel = '0;
    addr_all = '0;
    for (int b = 0; b < BANKS; b++) begin
      if ((b / GRP) == int'(grp)) begin
        bank_sel[b] = 1'b1;
`ifdef REF_LOADER_SKEW_EN
        // Skew by the group index so a column read hits a different line per group.
        addr_all[b*ADDR_W +: ADDR_W] = base + ADDR_W'(b / GRP);
`else
        addr_all[b*ADDR_W +: ADDR_W] = base;
`endif
      end
    end
  end

endmodule

// File: rtl/ref_mem_loader.sv
// Purpose: sequence one search-window load per start into the 32-bank reference memory.
// Latency: write port registered, 1 cycle after beat acceptance; load_done 1 cycle after last write.
// Backpressure: s_ready high only in LOAD; one row accepted per clock, none while idle or flushing.
// Ports: clk, rst_n (async active-low); start/num_rows load request; bus (master) carries the
// s_data/s_valid/s_ready stream and ref_input/Bank_sel/write_address_all; busy, load_done, cfg_err status.
// Macro REF_LOADER_SKEW_EN (in ref_wr_addr_gen) enables diagonal address skew.
module ref_mem_loader
  import ref_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_rows,
  ref_mem_loader_if.master       bus,
  output logic                   busy,
  output logic                   load_done,
  output logic                   cfg_err
);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        n_rows;
  logic [ROW_W-1:0]        row;
  logic                    accept;
  logic                    last_row;
  logic                    latch_cfg;
  logic                    done_nxt;
  logic                    err_nxt;

  logic [BANKS-1:0]        sel_c;
  logic [BANKS*ADDR_W-1:0] addr_c;

  logic [DATA_W-1:0]       ref_input_q;
  logic [BANKS-1:0]        bank_sel_q;
  logic [BANKS*ADDR_W-1:0] addr_q;

  assign accept   = bus.s_valid & bus.s_ready;
  assign last_row = ({1'b0, row} == (n_rows - CNT_W'(1)));

  ref_wr_addr_gen u_addr_gen (
    .row      (row),
    .bank_sel (sel_c),
    .addr_all (addr_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            done_nxt = 1'b1;
          end else if (num_rows > CNT_W'(MAX_ROWS)) begin
            err_nxt = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept && last_row) state_nxt = FLUSH;
      end
      FLUSH: begin
        // load_done lands in the cycle after the final write cycle.
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_rows      <= '0;
      row         <= '0;
      load_done   <= 1'b0;
      cfg_err     <= 1'b0;
      ref_input_q <= '0;
      bank_sel_q  <= '0;
      addr_q      <= '0;
    end else begin
      load_done <= done_nxt;
      cfg_err   <= err_nxt;
      if (latch_cfg) begin
        n_rows <= num_rows;
        row    <= '0;
      end else if (accept) begin
        row <= row + ROW_W'(1);
      end
      // Enables and addresses are single-cycle; data holds so the memory sees stable input.
      bank_sel_q <= accept ? sel_c  : '0;
      addr_q     <= accept ? addr_c : '0;
      if (accept) ref_input_q <= bus.s_data;
    end
  end

  assign bus.s_ready           = (state == LOAD);
  assign bus.ref_input         = ref_input_q;
  assign bus.Bank_sel          = bank_sel_q;
  assign bus.write_address_all = addr_q;
  assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_ref_mem_loader.sv
// Purpose: directed scoreboard bench for ref_mem_loader.
// Latency: expects write 1 cycle after acceptance, load_done 1 cycle after last write.
// Backpressure: beats wait on s_ready with a bounded cycle budget.
module tb_ref_mem_loader;
  import ref_mem_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic             busy, load_done, cfg_err;

  ref_mem_loader_if bus_if();

  ref_mem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .bus       (bus_if),
    .busy      (busy),
    .load_done (load_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int                row;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_wr = 0;

  function automatic logic [BANKS-1:0] exp_sel(int r);
    logic [BANKS-1:0] s = '0;
    for (int b = 0; b < BANKS; b++)
      if ((b / 4) == (r % 8)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [BANKS*ADDR_W-1:0] exp_addr(int r);
    logic [BANKS*ADDR_W-1:0] v = '0;
    int a;
    for (int b = 0; b < BANKS; b++) begin
      if ((b / 4) == (r % 8)) begin
        a = r / 8;
`ifdef REF_LOADER_SKEW_EN
        a = (a + b / 4) % 128;
`endif
        v[b*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
      end
    end
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every nonzero Bank_sel cycle must match the oldest pushed beat.
  always @(negedge clk) begin
    wr_t e;
    if (bus_if.Bank_sel != '0) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write", DATA_W'(bus_if.Bank_sel), '0);
      end else begin
        e = sb.pop_front();
        check("wr_sel",  DATA_W'(bus_if.Bank_sel),          DATA_W'(exp_sel(e.row)));
        check("wr_addr", DATA_W'(bus_if.write_address_all), DATA_W'(exp_addr(e.row)));
        check("wr_data", bus_if.ref_input,                  e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int n);
    start    = 1'b1;
    num_rows = CNT_W'(n);
    step();
    start    = 1'b0;
  endtask

  task automatic send(int r, logic [DATA_W-1:0] d);
    int t = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    while (!bus_if.s_ready && t < 100) begin
      step();
      t++;
    end
    if (!bus_if.s_ready) begin
      check("beat_timeout", '0, 1);
    end else begin
      sb.push_back('{r, d});
      step();
    end
    bus_if.s_valid = 1'b0;
  endtask

  // Called right after the last beat is accepted (FLUSH cycle).
  task automatic finish_load(string tag);
    check({tag, "_flush_ready"}, DATA_W'(bus_if.s_ready), 0);
    check({tag, "_flush_done"},  DATA_W'(load_done), 0);
    step();
    check({tag, "_done"},        DATA_W'(load_done), 1);
    check({tag, "_done_busy"},   DATA_W'(busy), 0);
    step();
    check({tag, "_done_clr"},    DATA_W'(load_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, t0;
    logic [DATA_W-1:0] d1;
    logic [ADDR_W-1:0] last_a;

    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    repeat (3) step();
    check("rst_sel",   DATA_W'(bus_if.Bank_sel), 0);
    check("rst_addr",  DATA_W'(bus_if.write_address_all), 0);
    check("rst_data",  bus_if.ref_input, 0);
    check("rst_busy",  DATA_W'(busy), 0);
    check("rst_done",  DATA_W'(load_done), 0);
    check("rst_err",   DATA_W'(cfg_err), 0);
    check("rst_ready", DATA_W'(bus_if.s_ready), 0);
    rst_n = 1'b1;
    step();

    // Stream valid with no load active is not accepted.
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = rnd_data();
    step();
    check("idle_ready", DATA_W'(bus_if.s_ready), 0);
    bus_if.s_valid = 1'b0;
    step();

    // 1: single row
    w0 = n_wr;
    do_start(1);
    check("t1_busy",  DATA_W'(busy), 1);
    check("t1_ready", DATA_W'(bus_if.s_ready), 1);
    d1 = {32{8'h01}};
    send(0, d1);
    check("t1_sel_now", DATA_W'(bus_if.Bank_sel), 32'h0000000F);
    finish_load("t1");
    check("t1_writes", DATA_W'(n_wr - w0), 1);

    // 2: twelve rows back-to-back
    w0 = n_wr;
    do_start(12);
    t0 = cyc;
    for (int r = 0; r < 12; r++) send(r, rnd_data());
    check("t2_b2b_cycles", DATA_W'(cyc - t0), 12);
    finish_load("t2");
    check("t2_writes", DATA_W'(n_wr - w0), 12);

    // 3: gapped stream, with a start pulse while busy that must be ignored
    w0 = n_wr;
    do_start(4);
    for (int r = 0; r < 4; r++) begin
      send(r, rnd_data());
      if (r < 3) begin
        if (r == 1) begin
          start    = 1'b1;
          num_rows = CNT_W'(5);
        end
        step();
        start = 1'b0;
        check("t3_gap_sel", DATA_W'(bus_if.Bank_sel), 0);
      end
    end
    finish_load("t3");
    repeat (3) step();
    check("t3_busy_after", DATA_W'(busy), 0);
    check("t3_writes", DATA_W'(n_wr - w0), 4);

    // 4: zero-length and oversize requests
    w0 = n_wr;
    do_start(0);
    check("t4_zero_done", DATA_W'(load_done), 1);
    check("t4_zero_busy", DATA_W'(busy), 0);
    step();
    check("t4_zero_clr",  DATA_W'(load_done), 0);
    do_start(1025);
    check("t4_err",       DATA_W'(cfg_err), 1);
    check("t4_err_busy",  DATA_W'(busy), 0);
    check("t4_err_done",  DATA_W'(load_done), 0);
    step();
    check("t4_err_clr",   DATA_W'(cfg_err), 0);
    check("t4_err_busy2", DATA_W'(busy), 0);
    check("t4_writes",    DATA_W'(n_wr - w0), 0);

    // 5: full 1024-row load
    w0 = n_wr;
    do_start(1024);
    for (int r = 0; r < 1024; r++) send(r, rnd_data());
`ifdef REF_LOADER_SKEW_EN
    last_a = 7'd6;
`else
    last_a = 7'd127;
`endif
    check("t5_last_sel",  DATA_W'(bus_if.Bank_sel), 32'hF0000000);
    check("t5_last_addr", DATA_W'(bus_if.write_address_all[31*ADDR_W +: ADDR_W]), DATA_W'(last_a));
    finish_load("t5");
    check("t5_writes", DATA_W'(n_wr - w0), 1024);

    // 6: reset mid-load, then a fresh load restarts at row 0
    w0 = n_wr;
    do_start(10);
    for (int r = 0; r < 5; r++) send(r, rnd_data());
    #5;
    rst_n = 1'b0;
    #1;
    check("t6_sel",   DATA_W'(bus_if.Bank_sel), 0);
    check("t6_addr",  DATA_W'(bus_if.write_address_all), 0);
    check("t6_data",  bus_if.ref_input, 0);
    check("t6_busy",  DATA_W'(busy), 0);
    check("t6_ready", DATA_W'(bus_if.s_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_no_done", DATA_W'(load_done), 0);
    do_start(2);
    send(0, rnd_data());
    send(1, rnd_data());
    finish_load("t6");
    check("t6_writes", DATA_W'(n_wr - w0), 7);

    step();
    check("sb_empty", DATA_W'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
